// File: rtl/imply_stack.sv
// LIFO of implied {var_idx, val} assignments. The top entry lives in a register so
// it can be presented directly; older entries sit in mem[0 .. count-2].
module imply_stack #(
  parameter int DEPTH = 512,
  parameter int VAR_W = 9,
  parameter int CNT_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             imply_stack_write_en,
  input  logic [VAR_W-1:0] var_idx_in,
  input  logic             val_in,
  input  logic             flush,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [VAR_W-1:0] var_idx_out,
  output logic             val_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [VAR_W-1:0] idx;
    logic             val;
  } entry_t;

  typedef enum logic {EMPTY, ACTIVE} state_t;

  entry_t           mem [DEPTH];
  entry_t           top_q, top_d, new_e;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, cnt_m1, cnt_m2;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             do_push, do_pop, mem_we;
  logic [AW-1:0]    wr_ptr, rd_ptr;

  assign new_e  = '{idx: var_idx_in, val: val_in};
  assign cnt_m1 = count_q - CNT_W'(1);
  assign cnt_m2 = count_q - CNT_W'(2);
  assign wr_ptr = cnt_m1[AW-1:0];
  assign rd_ptr = cnt_m2[AW-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    top_d   = top_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    mem_we  = 1'b0;
    if (flush) begin
      count_d = '0;
      top_d   = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      do_push = imply_stack_write_en;
      do_pop  = (state_q == ACTIVE) && pop_ready;
      if (pop_ready && state_q == EMPTY) udf_d = 1'b1;
      if (do_push && do_pop) begin
        // replace in place: count unchanged, legal even when full
        top_d = new_e;
      end else if (do_push) begin
        if (count_q == DEPTH_C) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
          top_d   = new_e;
          mem_we  = (state_q == ACTIVE);
        end
      end else if (do_pop) begin
        count_d = cnt_m1;
        top_d   = (count_q == CNT_W'(1)) ? entry_t'('0) : mem[rd_ptr];
      end
    end
    state_d = (count_d == '0) ? EMPTY : ACTIVE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // the displaced top slides down into the array; contents need no reset
  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_ptr] <= top_q;
  end

  assign out_valid   = (state_q == ACTIVE);
  assign var_idx_out = top_q.idx;
  assign val_out     = top_q.val;
  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
endmodule
